// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads instruction memory, buffers one instruction for IF/ID.
// Latency: a transfer at edge N is presented on ram_out_ins in cycle N+1; one instruction per cycle when streaming.
// Backpressure: pc_pause holds a full buffer and drops mem_req; branch_taken flushes the buffer and refetches from branch_target.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   pc_pause              downstream does not consume this cycle
//   branch_taken/_target  redirect fetch to branch_target (sampled at the edge)
//   mem_req/mem_addr      read request and address (= PC) to instruction memory
//   mem_ready/mem_rdata   read data valid for mem_addr this cycle
//   ram_out_ins           buffered instruction, or EMPTY_INS when the buffer is empty
//   pc_add_value          address of the buffered instruction + 1 (held when empty)
//   fetch_valid           buffer holds a valid instruction
module if_fetch_unit #(
  parameter int unsigned      PC_W      = 16,
  parameter int unsigned      INS_W     = 16,
  parameter logic [PC_W-1:0]  RESET_PC  = 16'h0000,
  parameter logic [INS_W-1:0] EMPTY_INS = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_pause,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  output logic             mem_req,
  output logic [PC_W-1:0]  mem_addr,
  input  logic             mem_ready,
  input  logic [INS_W-1:0] mem_rdata,
  output logic [INS_W-1:0] ram_out_ins,
  output logic [PC_W-1:0]  pc_add_value,
  output logic             fetch_valid
);

  typedef enum logic {
    S_REDIR = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [INS_W-1:0] r_ins_q;
  logic [PC_W-1:0]  r_npc_q;
  logic             r_fetch_valid;

  logic             w_mem_req;
  logic             w_transfer;
  logic             w_consume;
  logic [PC_W-1:0]  w_pc_inc;

  // Next-state and request logic. A request is made whenever the buffer
  // has room, either because it is empty or because it drains this edge.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = 1'b0;
    case (r_state)
      S_REDIR: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_FETCH;
        w_mem_req   = !r_fetch_valid || !pc_pause;
      end
      default: begin
        w_state_nxt = S_REDIR;
      end
    endcase
    // A redirect always parks one cycle in REDIR so memory sees mem_req drop.
    if (branch_taken) begin
      w_state_nxt = S_REDIR;
    end
  end

  assign w_transfer = w_mem_req && mem_ready;
  assign w_consume  = r_fetch_valid && !pc_pause;
  assign w_pc_inc   = r_pc + 1'b1;  // wraps modulo 2^PC_W

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REDIR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC and one-entry buffer. Redirect discards any same-edge transfer or
  // consume; npc_q is left untouched so pc_add_value holds while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_ins_q       <= '0;
      r_npc_q       <= RESET_PC;
      r_fetch_valid <= 1'b0;
    end else if (branch_taken) begin
      r_pc          <= branch_target;
      r_fetch_valid <= 1'b0;
    end else if (w_transfer) begin
      r_ins_q       <= mem_rdata;
      r_npc_q       <= w_pc_inc;
      r_fetch_valid <= 1'b1;
      r_pc          <= w_pc_inc;
    end else if (w_consume) begin
      r_fetch_valid <= 1'b0;
    end
  end

  assign mem_req      = w_mem_req;
  assign mem_addr     = r_pc;
  assign ram_out_ins  = r_fetch_valid ? r_ins_q : EMPTY_INS;
  assign pc_add_value = r_npc_q;
  assign fetch_valid  = r_fetch_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed vector bench for if_fetch_unit: per-cycle input/expected-output table,
// plus hand-written sequences for asynchronous reset and a bounded first fetch.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_pause;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic [15:0] ram_out_ins;
  logic [15:0] pc_add_value;
  logic        fetch_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Instruction memory model: data is a fixed function of the address.
  assign mem_rdata = mem_addr ^ 16'hA000;

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_pause      (pc_pause),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ram_out_ins   (ram_out_ins),
    .pc_add_value  (pc_add_value),
    .fetch_valid   (fetch_valid)
  );

  typedef struct {
    logic        rst;
    logic        pause;
    logic        br;
    logic [15:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic [15:0] e_ins;
    logic [15:0] e_npc;
    logic        e_vld;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic p, logic b, logic [15:0] t, logic rd,
                              logic q, logic [15:0] a, logic [15:0] ins,
                              logic [15:0] npc, logic v);
    vec_t x;
    x.rst = r; x.pause = p; x.br = b; x.tgt = t; x.rdy = rd;
    x.e_req = q; x.e_addr = a; x.e_ins = ins; x.e_npc = npc; x.e_vld = v;
    return x;
  endfunction

  task automatic chk(input string name, input int step, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, step, act, exp);
    end
  endtask

  task automatic chk_all(input int step, input logic q, input logic [15:0] a,
                         input logic [15:0] ins, input logic [15:0] npc, input logic v);
    chk("mem_req",      step, {15'd0, mem_req},     {15'd0, q});
    chk("mem_addr",     step, mem_addr,             a);
    chk("ram_out_ins",  step, ram_out_ins,          ins);
    chk("pc_add_value", step, pc_add_value,         npc);
    chk("fetch_valid",  step, {15'd0, fetch_valid}, {15'd0, v});
  endtask

  initial begin
    rst = 1'b0; pc_pause = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; mem_ready = 1'b0;

    //                rst p  b  tgt       rdy | req addr      ins       npc       vld
    vecs[0]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,16'h0800,16'h0000,1'b0); // reset
    vecs[1]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,16'h0800,16'h0000,1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,16'h0800,16'h0000,1'b0);
    vecs[3]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,16'h0000,16'h0800,16'h0000,1'b0); // released, REDIR
    vecs[4]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0000,16'h0800,16'h0000,1'b0); // first request
    vecs[5]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0001,16'hA000,16'h0001,1'b1); // streaming
    vecs[6]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0002,16'hA001,16'h0002,1'b1);
    vecs[7]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0003,16'hA002,16'h0003,1'b1);
    vecs[8]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0004,16'hA003,16'h0004,1'b1);
    vecs[9]  = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0005,16'hA004,16'h0005,1'b1);
    vecs[10] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0006,16'hA005,16'h0006,1'b1); // pause x3
    vecs[11] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0006,16'hA005,16'h0006,1'b1);
    vecs[12] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0006,16'hA005,16'h0006,1'b1);
    vecs[13] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0006,16'hA005,16'h0006,1'b1); // release
    vecs[14] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0007,16'hA006,16'h0007,1'b1); // wait states
    vecs[15] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0007,16'h0800,16'h0007,1'b0);
    vecs[16] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0007,16'h0800,16'h0007,1'b0);
    vecs[17] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0008,16'hA007,16'h0008,1'b1);
    vecs[18] = mk(1'b1,1'b0,1'b1,16'h0040,1'b1, 1'b1,16'h0008,16'h0800,16'h0008,1'b0); // redirect+transfer
    vecs[19] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'h0040,16'h0800,16'h0008,1'b0);
    vecs[20] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0040,16'h0800,16'h0008,1'b0);
    vecs[21] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0041,16'hA040,16'h0041,1'b1);
    vecs[22] = mk(1'b1,1'b0,1'b1,16'h0100,1'b1, 1'b1,16'h0042,16'hA041,16'h0042,1'b1); // back-to-back
    vecs[23] = mk(1'b1,1'b0,1'b1,16'hFFFF,1'b1, 1'b0,16'h0100,16'h0800,16'h0042,1'b0);
    vecs[24] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b0,16'hFFFF,16'h0800,16'h0042,1'b0);
    vecs[25] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'hFFFF,16'h0800,16'h0042,1'b0);
    vecs[26] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0000,16'h5FFF,16'h0000,1'b1); // wrap
    vecs[27] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0001,16'hA000,16'h0001,1'b1);
    vecs[28] = mk(1'b1,1'b1,1'b1,16'h0200,1'b1, 1'b0,16'h0002,16'hA001,16'h0002,1'b1); // redirect in pause
    vecs[29] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0200,16'h0800,16'h0002,1'b0);
    vecs[30] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,16'h0200,16'h0800,16'h0002,1'b0); // fill under pause
    vecs[31] = mk(1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b0,16'h0201,16'hA200,16'h0201,1'b1);
    vecs[32] = mk(1'b1,1'b0,1'b0,16'h0000,1'b1, 1'b1,16'h0201,16'hA200,16'h0201,1'b1);
    vecs[33] = mk(1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b1,16'h0202,16'hA201,16'h0202,1'b1);

    // Inputs change after the falling edge; outputs are checked before the rising edge.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      pc_pause      = vecs[i].pause;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      mem_ready     = vecs[i].rdy;
      #1;
      chk_all(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ins, vecs[i].e_npc, vecs[i].e_vld);
    end

    // Asynchronous reset in the middle of a cycle, with a request pending.
    @(negedge clk);
    pc_pause = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    #1;
    chk_all(100, 1'b1, 16'h0202, 16'h0800, 16'h0202, 1'b0);
    rst = 1'b0;
    #1;
    chk_all(101, 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    chk_all(102, 1'b0, 16'h0000, 16'h0800, 16'h0000, 1'b0);

    // Release reset with a zero-wait memory; first instruction must arrive within a bound.
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (!fetch_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("first_fetch_timeout", 103, {15'd0, fetch_valid}, 16'h0001);
      chk("first_fetch_cycles",  103, n[15:0],              16'h0002);
      chk("first_fetch_ins",     103, ram_out_ins,          16'hA000);
      chk("first_fetch_npc",     103, pc_add_value,         16'h0001);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
